// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage and IF/ID pipeline register for a classic five-stage
// in-order pipeline. Holds the program counter, drives a combinational
// instruction-memory read port, selects the next PC (hold / jump / branch /
// sequential) and registers the fetched instruction towards decode. It also
// keeps two saturating event counters for stalls and IF/ID flushes.
//
// Ports
//   clk              clock; every register updates on its rising edge
//   rst              synchronous, active-high reset
//   stall_F          hold the PC this cycle
//   stall_D          hold the IF/ID register this cycle
//   pc_src_d         branch resolved taken in decode
//   jmp_d            jump in decode (wins over pc_src_d)
//   branch_target_d  branch destination
//   jump_target_d    jump destination
//   imem_addr        instruction memory address (equals the PC register)
//   imem_rdata       instruction at imem_addr, same cycle
//   instr_d          registered instruction to decode (0 = NOP bubble)
//   pc_plus4_d       registered PC+4 belonging to instr_d
//   valid_d          instr_d is a real fetched instruction
//   stall_cnt        saturating count of cycles with stall_F=1
//   flush_cnt        saturating count of IF/ID flushes that took effect
//
// Handshake: there is no valid/ready pair here. The hazard unit owns flow
// control through stall_F/stall_D; a redirect (pc_src_d/jmp_d) is a level
// that decode keeps presenting until the stall that blocked it releases.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                  DATA_W   = 32,
    parameter logic [DATA_W-1:0]   RESET_PC = 32'h0000_0000,
    parameter int                  CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_F,
    input  logic                stall_D,
    input  logic                pc_src_d,
    input  logic                jmp_d,
    input  logic [DATA_W-1:0]   branch_target_d,
    input  logic [DATA_W-1:0]   jump_target_d,
    output logic [DATA_W-1:0]   imem_addr,
    input  logic [DATA_W-1:0]   imem_rdata,
    output logic [DATA_W-1:0]   instr_d,
    output logic [DATA_W-1:0]   pc_plus4_d,
    output logic                valid_d,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    // Redirect targets are word aligned by clearing the two low bits.
    localparam logic [DATA_W-1:0] ALIGN_MASK = {{(DATA_W-2){1'b1}}, 2'b00};
    localparam logic [DATA_W-1:0] PC_STEP    = DATA_W'(4);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] pc_q,       pc_d;
    logic [DATA_W-1:0] instr_q,    instr_d_nxt;
    logic [DATA_W-1:0] pc4_q,      pc4_d;
    logic              valid_q,    valid_d_nxt;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [DATA_W-1:0] pc_plus4_f;
    logic              redirect;
    logic              flush_fire;

    // Wraps naturally at DATA_W bits (0xFFFF_FFFC + 4 -> 0).
    assign pc_plus4_f = pc_q + PC_STEP;

    // The PC register itself is the memory address: no extra latency.
    assign imem_addr  = pc_q;

    assign redirect   = pc_src_d | jmp_d;

    // A redirect only empties IF/ID when IF/ID is allowed to move; a flush
    // swallowed by stall_D neither happens nor gets counted.
    assign flush_fire = redirect & ~stall_D;

    // ------------------------------------------------------------------
    // Next PC: stall hold > jump > branch > sequential
    // ------------------------------------------------------------------
    always_comb begin
        pc_d = pc_plus4_f;
        if (stall_F) begin
            pc_d = pc_q;
        end else if (jmp_d) begin
            pc_d = jump_target_d & ALIGN_MASK;
        end else if (pc_src_d) begin
            pc_d = branch_target_d & ALIGN_MASK;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register: hold > flush > load
    // ------------------------------------------------------------------
    always_comb begin
        instr_d_nxt = imem_rdata;
        pc4_d       = pc_plus4_f;
        valid_d_nxt = 1'b1;
        if (stall_D) begin
            instr_d_nxt = instr_q;
            pc4_d       = pc4_q;
            valid_d_nxt = valid_q;
        end else if (flush_fire) begin
            instr_d_nxt = '0;
            pc4_d       = '0;
            valid_d_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_F && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_fire && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Registers; reset overrides every pending stall or redirect.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            pc4_q       <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d_nxt;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d_nxt;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign instr_d    = instr_q;
    assign pc_plus4_d = pc4_q;
    assign valid_d    = valid_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int W     = 32;
    localparam int CNT_W = 16;
    localparam logic [W-1:0] TAG = 32'h5A5A_0000;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           stall_F, stall_D, pc_src_d, jmp_d;
    logic [W-1:0]   branch_target_d, jump_target_d;
    logic [W-1:0]   imem_addr, imem_rdata;
    logic [W-1:0]   instr_d, pc_plus4_d;
    logic           valid_d;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // Address-tagged instruction memory: word = address ^ TAG.
    assign imem_rdata = imem_addr ^ TAG;

    fetch_stage #(
        .DATA_W   (W),
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_F         (stall_F),
        .stall_D         (stall_D),
        .pc_src_d        (pc_src_d),
        .jmp_d           (jmp_d),
        .branch_target_d (branch_target_d),
        .jump_target_d   (jump_target_d),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .instr_d         (instr_d),
        .pc_plus4_d      (pc_plus4_d),
        .valid_d         (valid_d),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    // ------------------------------------------------------------------
    // Scoreboard: expected IF/ID contents {valid, pc_plus4, instr}
    // ------------------------------------------------------------------
    logic [2*W:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [W-1:0] word_at(input logic [W-1:0] a);
        return a ^ TAG;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input logic v, input logic [W-1:0] pc4, input logic [W-1:0] ins);
        exp_q.push_back({v, pc4, ins});
    endtask

    task automatic check_ifid(input string tag);
        logic [2*W:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".valid"},  {31'b0, valid_d}, {31'b0, e[2*W]});
            check({tag, ".pc4"},    pc_plus4_d,       e[2*W-1:W]);
            check({tag, ".instr"},  instr_d,          e[W-1:0]);
        end
    endtask

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_F         = 1'b0;
        stall_D         = 1'b0;
        pc_src_d        = 1'b0;
        jmp_d           = 1'b0;
        branch_target_d = '0;
        jump_target_d   = '0;
    endtask

    // One edge with the inputs currently driven; then compare IF/ID and PC.
    task automatic step(input string tag, input logic v, input logic [W-1:0] pc4,
                        input logic [W-1:0] ins, input logic [W-1:0] addr);
        push_exp(v, pc4, ins);
        tick();
        check_ifid(tag);
        check({tag, ".addr"}, imem_addr, addr);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst.addr",  imem_addr,  32'h0);
        check("rst.instr", instr_d,    32'h0);
        check("rst.pc4",   pc_plus4_d, 32'h0);
        check("rst.valid", {31'b0, valid_d}, 32'h0);
        check("rst.scnt",  {16'b0, stall_cnt}, 32'h0);
        check("rst.fcnt",  {16'b0, flush_cnt}, 32'h0);

        rst = 1'b0;
        check("post_rst.addr", imem_addr, 32'h0);

        // Free run: addresses 0,4,8,C, one-cycle fetch-to-decode
        step("run0", 1'b1, 32'h04, word_at(32'h00), 32'h04);
        step("run1", 1'b1, 32'h08, word_at(32'h04), 32'h08);
        step("run2", 1'b1, 32'h0C, word_at(32'h08), 32'h0C);
        step("run3", 1'b1, 32'h10, word_at(32'h0C), 32'h10);

        // Branch at pc 0x10 -> 0x40, one bubble
        pc_src_d = 1'b1;
        branch_target_d = 32'h40;
        step("br.bub", 1'b0, 32'h0, 32'h0, 32'h40);
        check("br.fcnt", {16'b0, flush_cnt}, 32'd1);
        idle_inputs();
        step("br.tgt", 1'b1, 32'h44, word_at(32'h40), 32'h44);

        // Jump and branch together: jump wins
        jmp_d = 1'b1;
        pc_src_d = 1'b1;
        jump_target_d = 32'h80;
        branch_target_d = 32'h40;
        step("jb.bub", 1'b0, 32'h0, 32'h0, 32'h80);
        check("jb.fcnt", {16'b0, flush_cnt}, 32'd2);
        idle_inputs();
        step("jb.tgt", 1'b1, 32'h84, word_at(32'h80), 32'h84);

        // Move to 0x1C so IF/ID holds a real instruction when pc reaches 0x20
        jmp_d = 1'b1;
        jump_target_d = 32'h1C;
        step("j1c.bub", 1'b0, 32'h0, 32'h0, 32'h1C);
        idle_inputs();
        step("j1c.tgt", 1'b1, 32'h20, word_at(32'h1C), 32'h20);

        // Two stall cycles at pc 0x20; branch pulse during stall is ignored
        stall_F = 1'b1;
        stall_D = 1'b1;
        step("stl0", 1'b1, 32'h20, word_at(32'h1C), 32'h20);
        pc_src_d = 1'b1;
        branch_target_d = 32'h40;
        step("stl1", 1'b1, 32'h20, word_at(32'h1C), 32'h20);
        check("stl.scnt", {16'b0, stall_cnt}, 32'd2);
        check("stl.fcnt", {16'b0, flush_cnt}, 32'd3);
        idle_inputs();
        step("stl.rel", 1'b1, 32'h24, word_at(32'h20), 32'h24);

        // PC wrap: jump to 0xFFFF_FFFC, next sequential address is 0
        jmp_d = 1'b1;
        jump_target_d = 32'hFFFF_FFFC;
        step("wrap.bub", 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        idle_inputs();
        step("wrap.tgt", 1'b1, 32'h0, word_at(32'hFFFF_FFFC), 32'h0);

        // Misaligned jump target gets its low bits cleared
        jmp_d = 1'b1;
        jump_target_d = 32'h43;
        step("algn.bub", 1'b0, 32'h0, 32'h0, 32'h40);
        check("algn.fcnt", {16'b0, flush_cnt}, 32'd5);
        idle_inputs();
        step("algn.tgt", 1'b1, 32'h44, word_at(32'h40), 32'h44);

        // Misaligned branch target
        pc_src_d = 1'b1;
        branch_target_d = 32'h8B;
        step("balg.bub", 1'b0, 32'h0, 32'h0, 32'h88);
        idle_inputs();

        // Reset during a stall and a jump discards both
        rst = 1'b1;
        stall_F = 1'b1;
        jmp_d = 1'b1;
        jump_target_d = 32'h80;
        step("rstmid", 1'b0, 32'h0, 32'h0, 32'h0);
        check("rstmid.scnt", {16'b0, stall_cnt}, 32'h0);
        check("rstmid.fcnt", {16'b0, flush_cnt}, 32'h0);
        rst = 1'b0;
        idle_inputs();
        step("rstmid.run", 1'b1, 32'h04, word_at(32'h00), 32'h04);

        // Stall counter saturation over 2^CNT_W + 3 stalled cycles
        stall_F = 1'b1;
        stall_D = 1'b1;
        for (int i = 0; i < (1 << CNT_W) - 2; i++) tick();
        check("sat.pre", {16'b0, stall_cnt}, 32'h0000_FFFE);
        for (int i = 0; i < 5; i++) tick();
        check("sat.max", {16'b0, stall_cnt}, 32'h0000_FFFF);
        check("sat.addr", imem_addr, 32'h04);
        rst = 1'b1;
        tick();
        check("sat.clr", {16'b0, stall_cnt}, 32'h0);
        rst = 1'b0;
        idle_inputs();

        check("sb.empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
